// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory access controller.
// Op encodings, controller states and default bus widths.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 4;
    localparam int DMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_FILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        STORE_WR,
        COPY_RD,
        COPY_WR,
        FILL_WR,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: command/response handshake between core and
// the data-memory access controller.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
    parameter int DATA_W = dmem_pkg::DMEM_DATA_W,
    parameter int LEN_W  = ADDR_W + 1
);

    logic              Req_Valid;
    logic              Req_Ready;
    logic [1:0]        Req_Op;
    logic [ADDR_W-1:0] Req_Addr;
    logic [ADDR_W-1:0] Req_Src;
    logic [LEN_W-1:0]  Req_Len;
    logic [DATA_W-1:0] Req_Data;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic [DATA_W-1:0] Rsp_Data;

    modport master (
        output Req_Valid, Req_Op, Req_Addr, Req_Src,
        output Req_Len, Req_Data, Rsp_Ready,
        input  Req_Ready, Rsp_Valid, Rsp_Data
    );

    modport slave (
        input  Req_Valid, Req_Op, Req_Addr, Req_Src,
        input  Req_Len, Req_Data, Rsp_Ready,
        output Req_Ready, Rsp_Valid, Rsp_Data
    );

endinterface

// File: rtl/dmem_addr_gen.sv
// dmem_addr_gen: block-command base registers and byte offset.
// Produces wrapped src/dst addresses and a last-byte flag.
module dmem_addr_gen
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [ADDR_W-1:0] src_next,
    output logic [ADDR_W-1:0] dst_next,
    output logic [LEN_W-1:0]  len,
    output logic              last
);

    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  off;
    logic [ADDR_W-1:0] off_a;

    // Latch bases and length on accept; advance one byte per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_base <= '0;
            dst_base <= '0;
            len      <= '0;
            off      <= '0;
        end else if (load) begin
            src_base <= src_in;
            dst_base <= dst_in;
            len      <= len_in;
            off      <= '0;
        end else if (step) begin
            off <= off + LEN_W'(1);
        end
    end

    assign off_a    = off[ADDR_W-1:0];
    assign dst_addr = dst_base + off_a;
    assign src_next = src_base + off_a + ADDR_W'(1);
    assign dst_next = dst_addr + ADDR_W'(1);
    assign last     = (off + LEN_W'(1)) == len;

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences load/store/copy/fill commands onto the
// data memory pins and returns one response per command.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LEN_W  = ADDR_W + 1
)
(
    input  logic              Clock,
    input  logic              Reset_n,
    dmem_access_ctrl_if.slave bus,
    output logic              Busy,
    output logic              Mem_Write_Enable,
    output logic [ADDR_W-1:0] Mem_Write_Address,
    output logic [ADDR_W-1:0] Mem_Read_Address,
    output logic [DATA_W-1:0] Mem_Data_In,
    input  logic [DATA_W-1:0] Mem_Data_Out
);

    state_e            state;
    state_e            state_d;
    logic              rst_done;
    logic              req_ready;
    logic              accept;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [ADDR_W-1:0] raddr_d;
    logic [DATA_W-1:0] din_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_data_d;
    logic              ag_load;
    logic              ag_step;
    logic [ADDR_W-1:0] ag_dst;
    logic [ADDR_W-1:0] ag_src_nx;
    logic [ADDR_W-1:0] ag_dst_nx;
    logic [LEN_W-1:0]  ag_len;
    logic              ag_last;

    dmem_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .load     (ag_load),
        .step     (ag_step),
        .src_in   (bus.Req_Src),
        .dst_in   (bus.Req_Addr),
        .len_in   (bus.Req_Len),
        .dst_addr (ag_dst),
        .src_next (ag_src_nx),
        .dst_next (ag_dst_nx),
        .len      (ag_len),
        .last     (ag_last)
    );

    assign req_ready     = rst_done && (state == IDLE);
    assign accept        = bus.Req_Valid && req_ready;
    assign bus.Req_Ready = req_ready;
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Rsp_Data  = rsp_data_q;
    assign Busy          = state != IDLE;

    // State register plus registered memory pins and response.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state             <= IDLE;
            rst_done          <= 1'b0;
            Mem_Write_Enable  <= 1'b0;
            Mem_Write_Address <= '0;
            Mem_Read_Address  <= '0;
            Mem_Data_In       <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_data_q        <= '0;
        end else begin
            state             <= state_d;
            rst_done          <= 1'b1;
            Mem_Write_Enable  <= we_d;
            Mem_Write_Address <= waddr_d;
            Mem_Read_Address  <= raddr_d;
            Mem_Data_In       <= din_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_data_q        <= rsp_data_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d     = state;
        we_d        = 1'b0;
        waddr_d     = Mem_Write_Address;
        raddr_d     = Mem_Read_Address;
        din_d       = Mem_Data_In;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        ag_load     = 1'b0;
        ag_step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ag_load = 1'b1;
                    unique case (op_e'(bus.Req_Op))
                        OP_LOAD: begin
                            state_d = LOAD_RD;
                            raddr_d = bus.Req_Addr;
                        end
                        OP_STORE: begin
                            state_d = STORE_WR;
                            we_d    = 1'b1;
                            waddr_d = bus.Req_Addr;
                            din_d   = bus.Req_Data;
                        end
                        OP_COPY: begin
                            if (bus.Req_Len == '0) begin
                                state_d    = RESP;
                                rsp_data_d = '0;
                            end else begin
                                state_d = COPY_RD;
                                raddr_d = bus.Req_Src;
                            end
                        end
                        OP_FILL: begin
                            if (bus.Req_Len == '0) begin
                                state_d    = RESP;
                                rsp_data_d = '0;
                            end else begin
                                state_d = FILL_WR;
                                we_d    = 1'b1;
                                waddr_d = bus.Req_Addr;
                                din_d   = bus.Req_Data;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            LOAD_RD: begin
                state_d    = RESP;
                rsp_data_d = Mem_Data_Out;
            end
            STORE_WR: begin
                state_d    = RESP;
                rsp_data_d = DATA_W'(1);
            end
            COPY_RD: begin
                state_d = COPY_WR;
                we_d    = 1'b1;
                waddr_d = ag_dst;
                din_d   = Mem_Data_Out;
            end
            COPY_WR: begin
                if (ag_last) begin
                    state_d    = RESP;
                    rsp_data_d = DATA_W'(ag_len);
                end else begin
                    state_d = COPY_RD;
                    ag_step = 1'b1;
                    raddr_d = ag_src_nx;
                end
            end
            FILL_WR: begin
                if (ag_last) begin
                    state_d    = RESP;
                    rsp_data_d = DATA_W'(ag_len);
                end else begin
                    ag_step = 1'b1;
                    we_d    = 1'b1;
                    waddr_d = ag_dst_nx;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && bus.Rsp_Ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed commands against a 16x8 memory with a
// command-level reference model and a per-cycle output checker.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    logic          busy;
    logic          mwe;
    logic [AW-1:0] mwa;
    logic [AW-1:0] mra;
    logic [DW-1:0] mdi;
    logic [DW-1:0] mdo;

    logic [DW-1:0] mem [16];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [DW-1:0] pl_d = '0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (mwe) mem[mwa] <= mdi;
    end
    assign mdo = mem[mra];

    dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .Clock             (clk),
        .Reset_n           (rst_n),
        .bus               (bus),
        .Busy              (busy),
        .Mem_Write_Enable  (mwe),
        .Mem_Write_Address (mwa),
        .Mem_Read_Address  (mra),
        .Mem_Data_In       (mdi),
        .Mem_Data_Out      (mdo)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat = 0;
    int we_cnt = 0;
    bit active = 0;
    bit rdy_ok = 0;
    bit in_rst = 1;
    logic [DW-1:0] exp_rsp = '0;
    logic [DW-1:0] got_rsp = '0;
    logic [DW-1:0] mm [16];
    int wq_a [$];
    logic [DW-1:0] wq_d [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model's view of the command.
    initial begin
        forever begin
            int n;
            @(negedge clk);
            if (mwe) we_cnt++;
            if (in_rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_rsp_valid", bus.Rsp_Valid, 0);
                chk("rst_req_ready", bus.Req_Ready, 0);
                chk("rst_rsp_data", bus.Rsp_Data, 0);
                chk("rst_we", mwe, 0);
                chk("rst_waddr", mwa, 0);
                chk("rst_raddr", mra, 0);
                chk("rst_din", mdi, 0);
            end else begin
                n = cyc - acc_cyc;
                chk("rsp_valid", bus.Rsp_Valid, active && n >= lat);
                chk("busy", busy, active);
                chk("req_ready", bus.Req_Ready, !active && rdy_ok);
                if (active && n >= lat) chk("rsp_data", bus.Rsp_Data, exp_rsp);
                if (mwe) begin
                    if (wq_a.size() == 0) begin
                        chk("we_extra", mwe, 0);
                    end else begin
                        chk("we_addr", mwa, wq_a.pop_front());
                        chk("we_data", mdi, wq_d.pop_front());
                    end
                end
            end
        end
    end

    task automatic preload(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        pl_we = 1'b1;
        pl_a = AW'(a);
        pl_d = v;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
        mm[a] = v;
    endtask

    task automatic mem_check(input string nm);
        for (int i = 0; i < 16; i++) chk(nm, mem[i], mm[i]);
    endtask

    task automatic run_cmd(input op_e op, input int a, input int s,
                           input int l, input logic [DW-1:0] d,
                           input int hold, input bit pend, input int cut);
        @(negedge clk);
        bus.Req_Valid = 1'b1;
        bus.Req_Op = op;
        bus.Req_Addr = AW'(a);
        bus.Req_Src = AW'(s);
        bus.Req_Len = LW'(l);
        bus.Req_Data = d;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        active = 1;
        bus.Req_Valid = 1'b0;
        bus.Req_Addr = ~bus.Req_Addr;
        bus.Req_Src = ~bus.Req_Src;
        bus.Req_Len = '1;
        bus.Req_Data = 8'hEE;
        case (op)
            OP_LOAD: begin
                lat = 2;
                exp_rsp = mm[a];
            end
            OP_STORE: begin
                lat = 2;
                exp_rsp = 8'd1;
                mm[a] = d;
                wq_a.push_back(a);
                wq_d.push_back(d);
            end
            OP_COPY: begin
                lat = 2 * l + 1;
                exp_rsp = DW'(l);
                for (int i = 0; i < l; i++) begin
                    if (cut < 0 || i < cut) begin
                        mm[(a + i) % 16] = mm[(s + i) % 16];
                        wq_a.push_back((a + i) % 16);
                        wq_d.push_back(mm[(s + i) % 16]);
                    end
                end
            end
            default: begin
                lat = l + 1;
                exp_rsp = DW'(l);
                for (int i = 0; i < l; i++) begin
                    mm[(a + i) % 16] = d;
                    wq_a.push_back((a + i) % 16);
                    wq_d.push_back(d);
                end
            end
        endcase
        if (cut >= 0) begin
            repeat (2 * cut) @(posedge clk);
            #2;
            rst_n = 1'b0;
            in_rst = 1;
            active = 0;
            rdy_ok = 0;
            #1;
            chk("rst_now_busy", busy, 0);
            chk("rst_now_we", mwe, 0);
            chk("rst_now_rsp_valid", bus.Rsp_Valid, 0);
            chk("cut_writes_done", wq_a.size(), 0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            #1;
            rst_n = 1'b1;
            in_rst = 0;
            @(posedge clk);
            #1;
            rdy_ok = 1;
            mem_check("cut_mem");
            return;
        end
        repeat (lat) @(posedge clk);
        @(negedge clk);
        if (pend) begin
            bus.Req_Valid = 1'b1;
            bus.Req_Op = OP_STORE;
            bus.Req_Addr = '0;
            bus.Req_Data = 8'hFF;
        end
        repeat (hold) @(negedge clk);
        got_rsp = bus.Rsp_Data;
        bus.Rsp_Ready = 1'b1;
        @(posedge clk);
        #1;
        bus.Rsp_Ready = 1'b0;
        bus.Req_Valid = 1'b0;
        active = 0;
        chk("writes_done", wq_a.size(), 0);
        mem_check("mem");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        bus.Req_Valid = 1'b0;
        bus.Req_Op = '0;
        bus.Req_Addr = '0;
        bus.Req_Src = '0;
        bus.Req_Len = '0;
        bus.Req_Data = '0;
        bus.Rsp_Ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        in_rst = 0;
        @(posedge clk);
        #1;
        rdy_ok = 1;
        for (int i = 0; i < 16; i++) preload(i, 8'h00);

        w0 = we_cnt;
        run_cmd(OP_STORE, 3, 0, 0, 8'hA5, 0, 0, -1);
        chk("lit_store_rsp", got_rsp, 8'd1);
        chk("lit_store_pulses", we_cnt - w0, 1);
        chk("lit_mem3", mem[3], 8'hA5);

        run_cmd(OP_LOAD, 3, 0, 0, 8'h00, 2, 0, -1);
        chk("lit_load_rsp", got_rsp, 8'hA5);

        preload(2, 8'h77);
        run_cmd(OP_FILL, 14, 0, 4, 8'h3C, 1, 0, -1);
        chk("lit_fill_rsp", got_rsp, 8'd4);
        chk("lit_fill14", mem[14], 8'h3C);
        chk("lit_fill15", mem[15], 8'h3C);
        chk("lit_fill0", mem[0], 8'h3C);
        chk("lit_fill1", mem[1], 8'h3C);
        chk("lit_fill2", mem[2], 8'h77);

        for (int i = 0; i < 8; i++) preload(i, 8'(i));
        run_cmd(OP_COPY, 8, 0, 8, 8'h00, 0, 0, -1);
        chk("lit_copy_rsp", got_rsp, 8'd8);
        for (int i = 0; i < 8; i++) chk("lit_copy_dst", mem[8 + i], 8'(i));

        preload(0, 8'h11);
        run_cmd(OP_COPY, 1, 0, 4, 8'h00, 0, 0, -1);
        for (int i = 0; i < 5; i++) chk("lit_overlap", mem[i], 8'h11);
        chk("lit_overlap5", mem[5], 8'h05);

        w0 = we_cnt;
        run_cmd(OP_FILL, 5, 0, 0, 8'h99, 5, 1, -1);
        chk("lit_len0_rsp", got_rsp, 8'd0);
        chk("lit_len0_pulses", we_cnt - w0, 0);
        chk("lit_pend_mem0", mem[0], 8'h11);

        w0 = we_cnt;
        run_cmd(OP_FILL, 7, 0, 16, 8'h5A, 0, 0, -1);
        chk("lit_fill16_rsp", got_rsp, 8'd16);
        chk("lit_fill16_pulses", we_cnt - w0, 16);

        run_cmd(OP_COPY, 3, 12, 0, 8'h00, 0, 0, -1);
        chk("lit_copy0_rsp", got_rsp, 8'd0);

        for (int i = 0; i < 8; i++) preload(i, 8'h40 + 8'(i));
        for (int i = 8; i < 16; i++) preload(i, 8'hF0);
        run_cmd(OP_COPY, 8, 0, 8, 8'h00, 0, 0, 3);
        chk("lit_cut8", mem[8], 8'h40);
        chk("lit_cut10", mem[10], 8'h42);
        chk("lit_cut11", mem[11], 8'hF0);

        run_cmd(OP_LOAD, 9, 0, 0, 8'h00, 0, 0, -1);
        chk("lit_after_rst_load", got_rsp, 8'h41);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Initiator-side controller for the 16×8 data memory. It accepts load, store, block-copy and block-fill commands from the core over a valid/ready handshake. It sequences them onto the memory's write-enable/write-address/read-address/data-in pins and returns one response per command. It sits between the datapath and the data memory, and is the only block that drives the memory's write port.

## Interface

Parameters:
- ADDR_W, 4, memory address width (depth = 2^ADDR_W)
- DATA_W, 8, memory word width
- LEN_W, ADDR_W+1, block length width (0..2^ADDR_W)

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req_Valid  in  1  command present
- Req_Ready  out  1  controller can accept a command; high only in IDLE
- Req_Op  in  2  00 load, 01 store, 10 copy, 11 fill
- Req_Addr  in  ADDR_W  load/store address; destination base for copy/fill
- Req_Src  in  ADDR_W  source base for copy; ignored otherwise
- Req_Len  in  LEN_W  byte count for copy/fill; ignored for load/store
- Req_Data  in  DATA_W  store data / fill value
- Rsp_Valid  out  1  response present
- Rsp_Ready  in  1  consumer accepts response
- Rsp_Data  out  DATA_W  load: read byte; store: 1; copy/fill: bytes written
- Busy  out  1  high whenever state ≠ IDLE
- Mem_Write_Enable  out  1  to memory Write_Enable
- Mem_Write_Address  out  ADDR_W  to memory Write_Address
- Mem_Read_Address  out  ADDR_W  to memory Read_Address
- Mem_Data_In  out  DATA_W  to memory Data_In
- Mem_Data_Out  in  DATA_W  from memory Data_Out (combinational read)

## Operation

- States: IDLE, LOAD_RD, STORE_WR, COPY_RD, COPY_WR, FILL_WR, RESP.
- Accept: Req_Valid && Req_Ready at a rising edge. All request fields are latched into command registers, so request inputs are don't-care afterwards.
- Load: IDLE → LOAD_RD → RESP. In LOAD_RD, Mem_Read_Address = addr, and Mem_Data_Out is captured into Rsp_Data at the end of that cycle.
- Store: IDLE → STORE_WR → RESP. STORE_WR asserts Mem_Write_Enable for exactly one cycle, with Mem_Write_Address = addr and Mem_Data_In = data. Rsp_Data = 1.
- Copy: for i = 0..len-1, COPY_RD reads src+i into a byte holding register, then COPY_WR writes it to dst+i. After the last write → RESP with Rsp_Data = len.
- Fill: FILL_WR writes the fill value to dst+i, one byte per cycle, for i = 0..len-1 → RESP with Rsp_Data = len.
- Address arithmetic is modulo 2^ADDR_W, so bases plus offset wrap (e.g. dst 14, len 4 writes 14, 15, 0, 1).
- Len 0 for copy/fill: IDLE → RESP directly, Rsp_Data = 0, no memory write.
- Len > 16 cannot be represented. Len 16 touches every location exactly once.
- Copy always proceeds in ascending order. When regions overlap with dst in (src, src+len), already-written bytes are re-read. This propagation is the defined behaviour.
- RESP: Rsp_Valid held high, with Rsp_Data stable, until Rsp_Ready. The handshake moves to IDLE.
- Outside write states: Mem_Write_Enable = 0, and Mem_Write_Address / Mem_Data_In hold their last values.
- Reset mid-command: the controller returns immediately to IDLE and Mem_Write_Enable drops. Memory contents already written are kept. No response is issued.

## Timing

- Reset values: Req_Ready 0 during reset and 1 from the first edge after release; Rsp_Valid 0; Rsp_Data 0; Busy 0; Mem_Write_Enable 0; Mem_Write_Address 0; Mem_Read_Address 0; Mem_Data_In 0. All outputs are registered except Req_Ready and Busy, which decode from state.
- Accept edge = cycle 0. Load: Rsp_Valid rises at edge 2. Store: write in cycle 1, Rsp_Valid at edge 2.
- Copy of len N: 2N write/read cycles, Rsp_Valid at edge 2N+1. Fill of len N: Rsp_Valid at edge N+1. Len 0: Rsp_Valid at edge 1.
- Throughput: one command outstanding; the next accept happens the cycle after the Rsp handshake at the earliest (Req_Ready is 0 in RESP).
- Simultaneous Rsp_Ready and a pending Req_Valid in RESP: only the response completes that edge.

## Structure

- Shared package dmem_pkg: op encodings (OP_LOAD, OP_STORE, OP_COPY, OP_FILL), state enum, ADDR_W/DATA_W defaults.
- Sub-module dmem_addr_gen: holds base registers and the offset counter, and produces the wrapped src+i and dst+i addresses plus a last-byte flag.
- The controller instantiates dmem_addr_gen. The data memory is instantiated only in the bench/top.

## Test plan

- Store 0xA5 @3, then load @3 → Rsp_Data 0xA5 at edge 2; store Rsp_Data 1; exactly one Mem_Write_Enable pulse.
- Fill dst 14, len 4, value 0x3C → locations 14, 15, 0, 1 = 0x3C, location 2 unchanged, Rsp_Data 4 at edge 5.
- Copy src 0 → dst 8, len 8 with mem[i] = i → mem[8..15] = 0..7, Rsp_Valid at edge 17.
- Overlapping copy src 0 → dst 1, len 4 with mem[0] = 0x11 → mem[0..4] all 0x11.
- Len 0 fill → Rsp_Data 0 at edge 1, no write pulse. Rsp_Ready held low 5 cycles → Rsp_Valid/Rsp_Data stable, Req_Ready 0.
- Reset_n asserted mid-copy after 3 bytes → outputs at reset values immediately, bytes 0..2 written and rest untouched, no response, next command accepted normally.
